muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit that sits beside the ALU in the execute stage. It consumes the same SrcA/SrcB operands from the register file/operand muxes and returns MDResult to the writeback mux. It holds busy so the control unit can stall the PC while the multi-cycle operation completes. Multiply uses radix-2 shift-add; divide uses restoring division. Both run one bit per cycle.

## Interface
- WIDTH, 32, operand/result width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- MDCtl  input  3  op = instruction funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- SrcA  input  WIDTH  rs1 operand (multiplicand/dividend).
- SrcB  input  WIDTH  rs2 operand (multiplier/divisor).
- busy  output  1  high while iterating; start ignored.
- done  output  1  one-cycle pulse; MDResult valid.
- MDResult  output  WIDTH  result; held until the next accepted op completes.

## Operation
- States: IDLE, CALC, DONE.
- Start is accepted in IDLE or DONE when start=1.
  - SrcA, SrcB and MDCtl are latched at acceptance; later input changes are ignored.
  - Operand magnitudes and result sign are computed at acceptance.
- Transitions on accept:
  - Special case → DONE.
  - Otherwise → CALC with counter = WIDTH-1.
- CALC: one iteration per cycle. At counter==0 → DONE; otherwise decrement.
- DONE: done=1, MDResult loaded. Next state is CALC/DONE if a new start is accepted, else IDLE.
- Multiply:
  - Form the 2·WIDTH unsigned product of the magnitudes.
  - Negate it if the result is negative.
  - Signedness: MUL and MULH treat both operands as signed. MULHSU treats SrcA signed, SrcB unsigned. MULHU treats both unsigned.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide:
  - Restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Special cases (resolved at accept, no iteration):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → SrcA.
  - Signed overflow (SrcA = 100…0, SrcB = all ones) for DIV → 100…0; for REM → 0.
- Multiply has no special cases; operand 0 still iterates the full WIDTH cycles.
- Reset, including mid-operation: state IDLE, busy=0, done=0, MDResult=0, counter and datapath registers 0. An aborted op never asserts done.

## Timing
- Normal op, start accepted at edge k:
  - busy=1 during cycles k+1 … k+WIDTH.
  - At edge k+WIDTH+1: busy=0 and done=1, with MDResult valid for that cycle.
  - Latency is WIDTH+1 cycles; with WIDTH=32, done arrives 33 cycles after the start edge.
- Special case accepted at edge k: busy stays 0, and done=1 with MDResult valid at edge k+1.
- busy and done are never high together.
- Back-to-back: a start asserted during the done cycle is accepted at that cycle's closing edge. MDResult keeps the previous value until the new op's done.
- start while busy=1 is ignored: no queueing, no effect on the running op.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
All values use WIDTH=32.
- MUL 7 × 0xFFFFFFFD (-3) → MDResult 0xFFFFFFEB. done exactly 33 cycles after the start edge; busy high for 32 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with done one cycle after start and busy never asserted:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Start abuse:
  - Pulse start with different operands while busy → the original result is returned unchanged.
  - Change SrcA/SrcB during CALC → no effect on the result.
- Assert rst mid-CALC (cycle 10) → busy=0, done=0, MDResult=0 immediately. No done afterwards. A subsequent MUL 3×4 → 12.
- Back-to-back: start MUL 3×5 asserted during the done cycle of DIVU 9/3 → first done shows 3, second done shows 15 exactly 33 cycles later.

Source files
------------

// File: rtl/muldiv_unit.sv
// Purpose: iterative RV32M multiply/divide (radix-2 shift-add multiply, restoring divide), one bit per cycle.
// Latency: WIDTH+1 cycles from the accepting edge to done; divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: busy is high while iterating; start is ignored while busy (no queueing).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             request, accepted when not busy (IDLE or DONE)
//   MDCtl[2:0]        funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcA, SrcB        rs1 / rs2 operands, latched at acceptance
//   busy              high while iterating
//   done              one-cycle pulse, MDResult valid
//   MDResult          result, held until the next accepted op completes
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       MDCtl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] MDResult
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [2:0]       op;
  logic             neg;       // final result must be negated
  logic [WIDTH-1:0] hi;        // multiply: product high half / divide: partial remainder
  logic [WIDTH-1:0] lo;        // multiply: multiplier shifting out / divide: dividend in, quotient out
  logic [WIDTH-1:0] opnd;      // multiplicand magnitude or divisor magnitude

  // ---------------- acceptance-side decode ----------------
  logic             a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (MDCtl)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:                   a_sgn = 1'b1;
      default:                ;
    endcase
  end

  assign a_neg  = a_sgn & SrcA[WIDTH-1];
  assign b_neg  = b_sgn & SrcB[WIDTH-1];
  assign a_mag  = a_neg ? -SrcA : SrcA;
  assign b_mag  = b_neg ? -SrcB : SrcB;
  // Remainder follows the dividend's sign; everything else follows the sign product.
  assign neg_in = (MDCtl[2] & MDCtl[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = MDCtl[2] && (SrcB == '0);
  assign div_ovf  = MDCtl[2] && !MDCtl[0] &&
                    (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
  assign special  = div_zero | div_ovf;
  // MDCtl[1] separates REM/REMU from DIV/DIVU.
  assign special_res = div_zero ? (MDCtl[1] ? SrcA : '1)
                                : (MDCtl[1] ? '0   : SrcA);

  // ---------------- one iteration ----------------
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     dshift;
  logic               dge;
  logic [WIDTH-1:0]   ddiff;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   mul_res, div_sel, div_res, fin;

  // Shift-add: add multiplicand into the high half when the outgoing multiplier bit is 1,
  // then shift the whole {carry, hi, lo} right by one.
  assign msum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
  // Restoring step: bring the next dividend bit into the remainder and subtract if it fits.
  assign dshift = {hi, lo[WIDTH-1]};
  assign dge    = (dshift >= {1'b0, opnd});
  assign ddiff  = dshift[WIDTH-1:0] - opnd;

  assign hi_n = op[2] ? (dge ? ddiff : dshift[WIDTH-1:0]) : msum[WIDTH:1];
  assign lo_n = op[2] ? {lo[WIDTH-2:0], dge} : {msum[0], lo[WIDTH-1:1]};

  // Result formed from the final iteration's next values so it lands in the DONE edge.
  assign prod    = {hi_n, lo_n};
  assign prod_s  = neg ? -prod : prod;
  assign mul_res = (op[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
  assign div_sel = op[1] ? hi_n : lo_n;
  assign div_res = neg ? -div_sel : div_sel;
  assign fin     = op[2] ? div_res : mul_res;

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      op       <= '0;
      neg      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      MDResult <= '0;
    end else begin
      case (state)
        CALC: begin
          hi <= hi_n;
          lo <= lo_n;
          if (count == '0) begin
            state    <= DONE;
            MDResult <= fin;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin  // IDLE or DONE: ready for a new op
          if (start) begin
            op  <= MDCtl;
            neg <= neg_in;
            if (special) begin
              state    <= DONE;
              MDResult <= special_res;
            end else begin
              state <= CALC;
              count <= CW'(WIDTH - 1);
              hi    <= '0;
              lo    <= MDCtl[2] ? a_mag : b_mag;
              opnd  <= MDCtl[2] ? b_mag : a_mag;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Decoded straight from the state register, so no input reaches an output combinationally.
  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose: scoreboard bench for muldiv_unit; driver pushes expected results, a monitor pops on done.
// Latency: checks done arrives 33 edges after acceptance (1 for divide specials) and busy run length.
// Backpressure: driver waits out busy, pulsing garbage start/operands meanwhile to show they are ignored.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  MDCtl = '0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        busy, done;
  logic [31:0] MDResult;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .MDCtl(MDCtl),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .MDResult(MDResult)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  op;
    int          lat;   // edges from acceptance to the edge that samples done
    int          acc;   // accepting edge number
  } exp_t;

  exp_t sbq[$];
  int   compared = 0;
  int   errors   = 0;

  // Behavioural reference: plain signed/unsigned arithmetic from the ISA rules.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sbv = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    int          q;
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: runs on the falling edge, pops one expectation per done pulse.
  task automatic monitor();
    int   busy_run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run = 0;
      end else begin
        compared++;
        if (busy && done) begin
          errors++;
          $display("FAIL busy_done_overlap cyc=%0d busy=%b done=%b required not both 1", cyc, busy, done);
        end
        if (busy) busy_run++;
        if (done) begin
          compared++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done cyc=%0d result=%h required no done", cyc, MDResult);
          end else begin
            e = sbq.pop_front();
            if (MDResult !== e.res) begin
              errors++;
              $display("FAIL result op=%0d got=%h required=%h", e.op, MDResult, e.res);
            end
            // done is high in the cycle that ends at edge cyc+1
            compared++;
            if (cyc + 1 - e.acc != e.lat) begin
              errors++;
              $display("FAIL latency op=%0d got=%0d required=%0d", e.op, cyc + 1 - e.acc, e.lat);
            end
            compared++;
            if (busy_run != e.lat - 1) begin
              errors++;
              $display("FAIL busy_cycles op=%0d got=%0d required=%0d", e.op, busy_run, e.lat - 1);
            end
          end
          busy_run = 0;
        end
      end
    end
  endtask

  // Issue one op; called on a falling edge. Waits out busy while abusing start.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv);
    int   guard = 0;
    exp_t e;
    while (busy && guard < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1; MDCtl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    compared++;
    if (busy) begin
      errors++;
      $display("FAIL busy_timeout busy=%b required 0 within 200 cycles", busy);
    end
    start = 1'b1; MDCtl = op; SrcA = a; SrcB = b;
    e.res = expv;
    e.op  = op;
    e.lat = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    // Scramble inputs after acceptance; the running op must not see them.
    start = 1'b0; MDCtl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          guard;

    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
    compared++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", done); end
    compared++;
    if (MDResult !== 32'h0) begin errors++; $display("FAIL reset_result got=%h required=0", MDResult); end
    #2 rst = 1'b0;
    @(negedge clk);

    // Directed results
    issue(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    issue(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    issue(3'd5, 32'd100,        32'd7,         32'd14);
    issue(3'd7, 32'd100,        32'd7,         32'd2);
    repeat (40) @(negedge clk);

    // Divide special cases, spaced out so each starts from IDLE
    issue(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF); repeat (3) @(negedge clk);
    issue(3'd6, 32'd5,          32'd0,         32'd5);         repeat (3) @(negedge clk);
    issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000); repeat (3) @(negedge clk);
    issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0);         repeat (3) @(negedge clk);

    // Start pulse while busy must not disturb the running op
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    repeat (5) @(negedge clk);
    start = 1'b1; MDCtl = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    start = 1'b0;

    // Back-to-back: second start lands in the first op's done cycle
    issue(3'd5, 32'd9, 32'd3, 32'd3);
    guard = 0;
    while (!done && guard < 100) begin @(negedge clk); guard++; end
    compared++;
    if (!done) begin errors++; $display("FAIL b2b_wait done=%b required 1 within 100 cycles", done); end
    issue(3'd0, 32'd3, 32'd5, 32'd15);

    // Reset in the middle of an iteration
    issue(3'd0, 32'h0001_2345, 32'h0000_0678, 32'h0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b required=0", busy); end
    compared++;
    if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b required=0", done); end
    compared++;
    if (MDResult !== 32'h0) begin errors++; $display("FAIL midrst_result got=%h required=0", MDResult); end
    sbq.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 32'd12);

    // Randomised ops against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      a  = rnd_val();
      b  = rnd_val();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, a, b, ref_model(op, a, b));
    end

    // Drain
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    compared++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule
